exc_arbiter: RTL and testbench
==============================

// Module: exc_arbiter
// PURPOSE
//  Exception/interrupt arbiter sitting directly upstream of cp0, at the MEM/commit boundary.
//  Collects per-instruction fault flags, pending interrupts and ERET from the MEM stage.
//  Picks one winner by MIPS priority and drives cp0's exception inputs as registered one-cycle pulses:
//  if_Exc, Exe_code, pc0, if_in_delay_dolt, addr_e, eret.
//  Also sequences the pipeline flush and the PC redirect to the exception vector or to EPC.
// PARAMETERS
//  EXC_VECTOR   32'hBFC0_0380  redirect target on any exception
//  FLUSH_CYCLES 2              cycles flush stays high per event (1..15)
// PORTS
//  clk          in   1   clock, all state on posedge
//  resetn       in   1   asynchronous, active-low reset
//  stall        in   1   pipeline pause; MEM instruction not committing this cycle
//  mem_valid    in   1   MEM stage holds a real instruction
//  mem_pc       in   32  PC of the MEM instruction
//  mem_bd       in   1   MEM instruction is in a branch delay slot
//  f_adel_if    in   1   fetch address error
//  f_ri         in   1   reserved instruction
//  f_ov         in   1   arithmetic overflow
//  f_sys        in   1   syscall
//  f_bp         in   1   break
//  f_adel_ld    in   1   load address error
//  f_ades_st    in   1   store address error
//  mem_daddr    in   32  data address of the load/store
//  mem_eret     in   1   MEM instruction is ERET
//  ext_int      in   6   hardware interrupt lines
//  cp0_status   in   32  cp0 Status readback
//  cp0_cause    in   32  cp0 Cause readback
//  cp0_epc      in   32  cp0 EPC readback
//  exc_valid    out  1   -> cp0 if_Exc
//  exc_code     out  5   -> cp0 Exe_code
//  exc_pc       out  32  -> cp0 pc0
//  exc_bd       out  1   -> cp0 if_in_delay_dolt
//  exc_badvaddr out  32  -> cp0 addr_e
//  eret_valid   out  1   -> cp0 eret
//  flush        out  1   kill IF..MEM contents
//  redirect_vld out  1   fetch must load redirect_pc
//  redirect_pc  out  32  new fetch PC
//  int_pending  out  1   combinational interrupt-pending indication
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; flush counter 0; int_q 0.
//  int_pending = |({int_q,cp0_cause[9:8]} & cp0_status[15:8]) & cp0_status[0] & ~cp0_status[1].
//  commit = mem_valid & ~stall & state==IDLE. With no commit, nothing is taken and the inputs are re-evaluated next cycle.
//  Priority, high->low:
//   Int=0x00 > AdEL-fetch=0x04 > RI=0x0A > Ov=0x0C > Sys=0x08 > Bp=0x09 > AdEL-load=0x04 > AdES=0x05.
//  Interrupt is taken only on commit, and is charged to mem_pc.
//  exc_badvaddr: mem_pc for fetch AdEL; mem_daddr for AdEL-load/AdES; otherwise holds its last value.
//  exc_pc = mem_bd ? mem_pc-4 : mem_pc (32-bit wrap). exc_bd = mem_bd.
//  Latency: fault sampled in cycle N -> exc_valid, flush, redirect_vld high in N+1.
//   exc_valid and redirect_vld last exactly 1 cycle.
//  ERET without fault or interrupt: eret_valid=1, redirect_pc=cp0_epc (sampled at N), flush as above.
//  ERET plus any fault or interrupt: the exception wins and eret_valid stays 0.
//  FSM:
//   IDLE -(exception|eret committed)-> FLUSH, load cnt=FLUSH_CYCLES-1.
//   FLUSH: flush=1; cnt decrements each cycle; at cnt==0 -> IDLE.
//   No new event is accepted in FLUSH, even if stall=0.
//  exc_code, exc_pc and redirect_pc hold their values after the pulse until the next event.
//  resetn low mid-FLUSH: flush, exc_valid and redirect_vld drop at once (async); state returns to IDLE.
// CONFIGURATION
//  EXC_INT_SYNC_EN defined:
//   ext_int passes through a 2-flop synchronizer into int_q (reset 0), so interrupts show 2 cycles later.
//  EXC_INT_SYNC_EN undefined:
//   int_q = ext_int combinationally; an interrupt can be taken in the same cycle it rises.
// TESTING
//  1 f_ov=1, mem_pc=0xBFC0_0100, mem_bd=0 -> next cycle exc_valid=1, exc_code=0x0C, exc_pc=0xBFC0_0100,
//    redirect_pc=0xBFC0_0380; flush high 2 cycles.
//  2 f_ades_st=1, mem_daddr=0x0000_1003, mem_bd=1, mem_pc=0x8000_0010 -> exc_code=0x05,
//    exc_badvaddr=0x0000_1003, exc_pc=0x8000_000C, exc_bd=1.
//  3 f_ri=1 and f_sys=1 together -> exc_code=0x0A only; one exc_valid pulse.
//  4 mem_eret=1, cp0_epc=0x8000_0200 -> eret_valid=1, redirect_pc=0x8000_0200, exc_valid=0;
//    repeat with f_ov=1 -> exc_valid=1, eret_valid=0.
//  5 status=0x0000_0401, ext_int[0]=1, stall=1 for 3 cycles -> no pulse;
//    stall falls -> exc_code=0x00 next cycle; with status[1]=1 -> no pulse.
//  6 f_bp in cycle N, then f_sys in N+1 (inside FLUSH) -> only Bp (0x09) reported;
//    resetn=0 during FLUSH -> all outputs 0 immediately.

Source files
------------

// File: rtl/exc_arbiter.sv
// Exception/interrupt arbiter feeding cp0, plus flush and PC-redirect sequencing.
// Optional macro EXC_INT_SYNC_EN: 2-flop synchronizer on ext_int before int_q.
module exc_arbiter #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic        f_adel_if,
    input  logic        f_ri,
    input  logic        f_ov,
    input  logic        f_sys,
    input  logic        f_bp,
    input  logic        f_adel_ld,
    input  logic        f_ades_st,
    input  logic [31:0] mem_daddr,
    input  logic        mem_eret,
    input  logic [5:0]  ext_int,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        exc_bd,
    output logic [31:0] exc_badvaddr,
    output logic        eret_valid,
    output logic        flush,
    output logic        redirect_vld,
    output logic [31:0] redirect_pc,
    output logic        int_pending
);

    localparam logic [4:0] EC_INT  = 5'h00;
    localparam logic [4:0] EC_ADEL = 5'h04;
    localparam logic [4:0] EC_ADES = 5'h05;
    localparam logic [4:0] EC_SYS  = 5'h08;
    localparam logic [4:0] EC_BP   = 5'h09;
    localparam logic [4:0] EC_RI   = 5'h0A;
    localparam logic [4:0] EC_OV   = 5'h0C;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        exc_valid_q, exc_valid_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exc_bd_q, exc_bd_d;
    logic [31:0] exc_badvaddr_q, exc_badvaddr_d;
    logic        eret_valid_q, eret_valid_d;
    logic        redirect_vld_q, redirect_vld_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [5:0]  int_q;
    logic        commit;
    logic        exc_hit;
    logic [4:0]  code_sel;
    logic [31:0] badv_sel;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            int_sync_q <= '0;
            int_q      <= '0;
        end else begin
            int_sync_q <= ext_int;
            int_q      <= int_sync_q;
        end
    end
`else
    assign int_q = ext_int;
`endif

    // IP[7:2] are hardware lines, IP[1:0] the software bits held in Cause.
    assign int_pending = |({int_q, cp0_cause[9:8]} & cp0_status[15:8])
                       & cp0_status[0] & ~cp0_status[1];

    assign commit = mem_valid & ~stall & (state_q == S_IDLE);

    always_comb begin
        exc_hit  = 1'b1;
        code_sel = EC_INT;
        badv_sel = exc_badvaddr_q;
        priority case (1'b1)
            int_pending: code_sel = EC_INT;
            f_adel_if: begin
                code_sel = EC_ADEL;
                badv_sel = mem_pc;
            end
            f_ri:  code_sel = EC_RI;
            f_ov:  code_sel = EC_OV;
            f_sys: code_sel = EC_SYS;
            f_bp:  code_sel = EC_BP;
            f_adel_ld: begin
                code_sel = EC_ADEL;
                badv_sel = mem_daddr;
            end
            f_ades_st: begin
                code_sel = EC_ADES;
                badv_sel = mem_daddr;
            end
            default: exc_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        exc_valid_d    = 1'b0;
        eret_valid_d   = 1'b0;
        redirect_vld_d = 1'b0;
        exc_code_d     = exc_code_q;
        exc_pc_d       = exc_pc_q;
        exc_bd_d       = exc_bd_q;
        exc_badvaddr_d = exc_badvaddr_q;
        redirect_pc_d  = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (commit && (exc_hit || mem_eret)) begin
                    state_d        = S_FLUSH;
                    cnt_d          = CNT_INIT;
                    redirect_vld_d = 1'b1;
                    if (exc_hit) begin
                        exc_valid_d    = 1'b1;
                        exc_code_d     = code_sel;
                        exc_pc_d       = mem_bd ? mem_pc - 32'd4 : mem_pc;
                        exc_bd_d       = mem_bd;
                        exc_badvaddr_d = badv_sel;
                        redirect_pc_d  = EXC_VECTOR;
                    end else begin
                        eret_valid_d   = 1'b1;
                        redirect_pc_d  = cp0_epc;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            exc_valid_q    <= 1'b0;
            exc_code_q     <= '0;
            exc_pc_q       <= '0;
            exc_bd_q       <= 1'b0;
            exc_badvaddr_q <= '0;
            eret_valid_q   <= 1'b0;
            redirect_vld_q <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            exc_valid_q    <= exc_valid_d;
            exc_code_q     <= exc_code_d;
            exc_pc_q       <= exc_pc_d;
            exc_bd_q       <= exc_bd_d;
            exc_badvaddr_q <= exc_badvaddr_d;
            eret_valid_q   <= eret_valid_d;
            redirect_vld_q <= redirect_vld_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign exc_valid    = exc_valid_q;
    assign exc_code     = exc_code_q;
    assign exc_pc       = exc_pc_q;
    assign exc_bd       = exc_bd_q;
    assign exc_badvaddr = exc_badvaddr_q;
    assign eret_valid   = eret_valid_q;
    assign redirect_vld = redirect_vld_q;
    assign redirect_pc  = redirect_pc_q;
    assign flush        = (state_q == S_FLUSH);

    logic unused_bits;
    assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2],
                           cp0_cause[31:10], cp0_cause[7:0]};

endmodule

// File: tb/tb_exc_arbiter.sv
// Self-checking bench for exc_arbiter: directed cases then randomized traffic
// against a cycle-level reference model.
module tb_exc_arbiter;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          NFC = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall, mem_valid, mem_bd, mem_eret;
    logic [31:0] mem_pc, mem_daddr, cp0_status, cp0_cause, cp0_epc;
    logic        f_adel_if, f_ri, f_ov, f_sys, f_bp, f_adel_ld, f_ades_st;
    logic [5:0]  ext_int;
    logic        exc_valid, exc_bd, eret_valid, flush, redirect_vld, int_pending;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badvaddr, redirect_pc;

    exc_arbiter #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(NFC)) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .mem_valid(mem_valid),
        .mem_pc(mem_pc), .mem_bd(mem_bd), .f_adel_if(f_adel_if), .f_ri(f_ri),
        .f_ov(f_ov), .f_sys(f_sys), .f_bp(f_bp), .f_adel_ld(f_adel_ld),
        .f_ades_st(f_ades_st), .mem_daddr(mem_daddr), .mem_eret(mem_eret),
        .ext_int(ext_int), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
        .cp0_epc(cp0_epc), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
        .eret_valid(eret_valid), .flush(flush), .redirect_vld(redirect_vld),
        .redirect_pc(redirect_pc), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          busy;
    logic [31:0] m_ev, m_code, m_pc, m_bd, m_bv, m_er, m_rv, m_rp;
    logic [5:0]  h1, h2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] m_intq();
`ifdef EXC_INT_SYNC_EN
        return h2;
`else
        return ext_int;
`endif
    endfunction

    function automatic logic m_pend();
        logic [7:0] ip;
        ip = {m_intq(), cp0_cause[9:8]};
        return (|(ip & cp0_status[15:8])) && cp0_status[0] && !cp0_status[1];
    endfunction

    task automatic m_reset();
        busy = 0;
        m_ev = 0; m_code = 0; m_pc = 0; m_bd = 0;
        m_bv = 0; m_er = 0; m_rv = 0; m_rp = 0;
        h1 = 0; h2 = 0;
    endtask

    // Called right after each rising edge, with inputs as sampled there.
    task automatic m_update();
        logic        fl [8];
        logic [31:0] cd [8];
        int          win;
        fl = '{m_pend(), f_adel_if, f_ri, f_ov, f_sys, f_bp, f_adel_ld, f_ades_st};
        cd = '{32'h00, 32'h04, 32'h0A, 32'h0C, 32'h08, 32'h09, 32'h04, 32'h05};
        win = -1;
        for (int i = 7; i >= 0; i--) if (fl[i]) win = i;
        m_ev = 0; m_er = 0; m_rv = 0;
        if (busy > 0) begin
            busy--;
        end else if (mem_valid && !stall && (win >= 0 || mem_eret)) begin
            busy = NFC;
            m_rv = 1;
            if (win >= 0) begin
                m_ev   = 1;
                m_code = cd[win];
                m_pc   = mem_bd ? mem_pc - 32'd4 : mem_pc;
                m_bd   = 32'(mem_bd);
                m_rp   = VEC;
                if (win == 1) m_bv = mem_pc;
                if (win >= 6) m_bv = mem_daddr;
            end else begin
                m_er = 1;
                m_rp = cp0_epc;
            end
        end
        h2 = h1;
        h1 = ext_int;
    endtask

    task automatic check_all();
        chk("exc_valid", 32'(exc_valid), m_ev);
        chk("exc_code", 32'(exc_code), m_code);
        chk("exc_pc", exc_pc, m_pc);
        chk("exc_bd", 32'(exc_bd), m_bd);
        chk("badvaddr", exc_badvaddr, m_bv);
        chk("eret_valid", 32'(eret_valid), m_er);
        chk("redirect_vld", 32'(redirect_vld), m_rv);
        chk("redirect_pc", redirect_pc, m_rp);
        chk("flush", 32'(flush), 32'(busy > 0));
    endtask

    task automatic step();
        #1 chk("int_pending", 32'(int_pending), 32'(m_pend()));
        @(posedge clk);
        m_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic clr();
        stall = 0; mem_valid = 0; mem_bd = 0; mem_eret = 0;
        mem_pc = 0; mem_daddr = 0; cp0_status = 0; cp0_cause = 0;
        cp0_epc = 0; ext_int = 0;
        f_adel_if = 0; f_ri = 0; f_ov = 0; f_sys = 0; f_bp = 0;
        f_adel_ld = 0; f_ades_st = 0;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clr();
        resetn = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_exc_valid", 32'(exc_valid), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        resetn = 1;
        idle(2);

        // Overflow, flush held for two cycles
        mem_valid = 1; mem_pc = 32'hBFC0_0100; f_ov = 1;
        step();
        chk("t1_valid", 32'(exc_valid), 1);
        chk("t1_code", 32'(exc_code), 32'h0C);
        chk("t1_pc", exc_pc, 32'hBFC0_0100);
        chk("t1_rpc", redirect_pc, VEC);
        chk("t1_flush_a", 32'(flush), 1);
        idle(1);
        chk("t1_flush_b", 32'(flush), 1);
        chk("t1_pulse", 32'(exc_valid), 0);
        idle(1);
        chk("t1_flush_c", 32'(flush), 0);

        // Store address error in a delay slot
        mem_valid = 1; f_ades_st = 1; mem_daddr = 32'h0000_1003;
        mem_bd = 1; mem_pc = 32'h8000_0010;
        step();
        chk("t2_code", 32'(exc_code), 32'h05);
        chk("t2_badv", exc_badvaddr, 32'h0000_1003);
        chk("t2_pc", exc_pc, 32'h8000_000C);
        chk("t2_bd", 32'(exc_bd), 1);
        idle(2);

        // RI beats SYS
        mem_valid = 1; f_ri = 1; f_sys = 1; mem_pc = 32'h8000_0100;
        step();
        chk("t3_code", 32'(exc_code), 32'h0A);
        chk("t3_valid", 32'(exc_valid), 1);
        step();
        chk("t3_once", 32'(exc_valid), 0);
        idle(2);

        // ERET alone, then ERET with overflow
        mem_valid = 1; mem_eret = 1; cp0_epc = 32'h8000_0200;
        step();
        chk("t4_eret", 32'(eret_valid), 1);
        chk("t4_rpc", redirect_pc, 32'h8000_0200);
        chk("t4_noexc", 32'(exc_valid), 0);
        idle(2);
        mem_valid = 1; mem_eret = 1; cp0_epc = 32'h8000_0200; f_ov = 1;
        step();
        chk("t4b_exc", 32'(exc_valid), 1);
        chk("t4b_eret", 32'(eret_valid), 0);
        chk("t4b_rpc", redirect_pc, VEC);
        idle(2);

        // Interrupt held off by stall, then masked by EXL
        mem_valid = 1; mem_pc = 32'h8000_0300; cp0_status = 32'h0000_0401;
        ext_int = 6'h01; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_stalled", 32'(exc_valid), 0);
        end
        stall = 0;
        step();
        chk("t5_valid", 32'(exc_valid), 1);
        chk("t5_code", 32'(exc_code), 32'h00);
        chk("t5_pc", exc_pc, 32'h8000_0300);
        idle(2);
        mem_valid = 1; cp0_status = 32'h0000_0403; ext_int = 6'h01;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_exl", 32'(exc_valid), 0);
        end
        idle(2);

        // Second fault inside FLUSH is ignored
        mem_valid = 1; f_bp = 1; mem_pc = 32'h8000_0400;
        step();
        chk("t6_code", 32'(exc_code), 32'h09);
        f_bp = 0; f_sys = 1;
        step();
        chk("t6_ignored", 32'(exc_valid), 0);
        chk("t6_hold", 32'(exc_code), 32'h09);
        idle(2);

        // Asynchronous reset in the middle of FLUSH
        mem_valid = 1; f_ov = 1; mem_pc = 32'h8000_0500;
        step();
        #2 resetn = 0;
        #1;
        chk("t6r_flush", 32'(flush), 0);
        chk("t6r_valid", 32'(exc_valid), 0);
        chk("t6r_rvld", 32'(redirect_vld), 0);
        chk("t6r_code", 32'(exc_code), 0);
        chk("t6r_rpc", redirect_pc, 0);
        m_reset();
        clr();
        @(negedge clk);
        resetn = 1;
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mem_valid = ($urandom % 4) != 0;
            stall     = ($urandom % 4) == 0;
            mem_bd    = $urandom % 2;
            mem_pc    = ($urandom % 16 == 0) ? 32'($urandom % 4) : $urandom;
            mem_daddr = $urandom;
            mem_eret  = ($urandom % 8) == 0;
            cp0_epc   = $urandom;
            f_adel_if = ($urandom % 14) == 0;
            f_ri      = ($urandom % 14) == 0;
            f_ov      = ($urandom % 14) == 0;
            f_sys     = ($urandom % 14) == 0;
            f_bp      = ($urandom % 14) == 0;
            f_adel_ld = ($urandom % 14) == 0;
            f_ades_st = ($urandom % 14) == 0;
            ext_int   = ($urandom % 6 == 0) ? 6'($urandom) : 6'h00;
            cp0_cause = ($urandom % 10 == 0) ? $urandom : ($urandom & 32'hFFFF_FCFF);
            cp0_status = $urandom;
            cp0_status[1] = ($urandom % 4) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
